dmem_dp: RTL and testbench

Parametrised dual-port data memory for the contest core's load/store path; successor to the fixed-width, asynchronously read data memory. Two independent request/grant ports with byte-write enables, a registered 1-cycle read, same-cycle cross-port write forwarding, out-of-range detection, and a post-reset clear sequencer. It sits between the core's memory stage (port A) and the second load/store or debug/DMA master (port B).

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_dp_array.sv | 68 ++++++
 rtl/dmem_dp.sv | 136 +++++++++++++
 tb/tb_dmem_dp.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dual-port data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } dmem_state_e;

  localparam int unsigned INIT_MODE_FILE  = 0;
  localparam int unsigned INIT_MODE_CLEAR = 1;

  // merge_be works on the widest supported word; callers widen and narrow around it.
  localparam int unsigned MERGE_W    = 256;
  localparam int unsigned MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] merge_be(input logic [MERGE_W-1:0]    old_w,
                                                  input logic [MERGE_W-1:0]    new_w,
                                                  input logic [MERGE_BE_W-1:0] be);
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(MERGE_BE_W); i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_dp_array.sv
// Raw storage: two byte-enabled write ports, two registered read ports that
// return the post-write word when the other port writes the same address.
module dmem_dp_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned IDX_W     = 10,
  parameter int unsigned INIT_MODE = 0,
  parameter string       INIT_FILE = "dmem.dat"
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wa_en,
  input  logic [IDX_W-1:0]    wa_addr,
  input  logic [DATA_W-1:0]   wa_data,
  input  logic [DATA_W/8-1:0] wa_be,
  input  logic                wb_en,
  input  logic [IDX_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic [DATA_W/8-1:0] wb_be,
  input  logic                ra_en,
  input  logic                ra_ok,
  input  logic [IDX_W-1:0]    ra_addr,
  output logic [DATA_W-1:0]   ra_data,
  input  logic                rb_en,
  input  logic                rb_ok,
  input  logic [IDX_W-1:0]    rb_addr,
  output logic [DATA_W-1:0]   rb_data
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] o,
                                                   input logic [DATA_W-1:0] n,
                                                   input logic [BE_W-1:0]   be);
    return DATA_W'(merge_be(MERGE_W'(o), MERGE_W'(n), MERGE_BE_W'(be)));
  endfunction

  // Word as it will look after this cycle's writes land.
  function automatic logic [DATA_W-1:0] post_write(input logic [IDX_W-1:0] ra);
    logic [DATA_W-1:0] w;
    w = mem[ra];
    if (wa_en && (wa_addr == ra)) w = merge_word(w, wa_data, wa_be);
    if (wb_en && (wb_addr == ra)) w = merge_word(w, wb_data, wb_be);
    return w;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(BE_W); i++) begin
      if (wa_en && wa_be[i]) mem[wa_addr][i*8 +: 8] <= wa_data[i*8 +: 8];
      if (wb_en && wb_be[i]) mem[wb_addr][i*8 +: 8] <= wb_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_data <= '0;
      rb_data <= '0;
    end else begin
      if (ra_en) ra_data <= ra_ok ? post_write(ra_addr) : '0;
      if (rb_en) rb_data <= rb_ok ? post_write(rb_addr) : '0;
    end
  end

endmodule

// File: rtl/dmem_dp.sv
// Dual-port data memory: clear sequencer, range checks, write collision
// resolution (port B wins per byte) and registered rvalid/err.
module dmem_dp
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned INIT_MODE = 0,
  parameter string       INIT_FILE = "dmem.dat"
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_be,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_err,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_be,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_err,
  output logic                init_done
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0] DEPTH_C  = CMP_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  dmem_state_e      state;
  logic [IDX_W-1:0] clr_cnt;

  // Sequencer: INIT -> (CLEAR sweep) -> READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= '0;
          if (INIT_MODE == INIT_MODE_CLEAR) begin
            state <= ST_CLEAR;
          end else begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + IDX_W'(1);
          end
        end
        ST_READY: state <= ST_READY;
        default: begin
          state     <= ST_INIT;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  logic            clr_act;
  logic            a_ok, b_ok, a_wr, b_wr, a_rd, b_rd;
  logic [BE_W-1:0] a_be_eff;

  assign a_gnt   = a_req & init_done;
  assign b_gnt   = b_req & init_done;
  assign a_ok    = CMP_W'(a_addr) < DEPTH_C;
  assign b_ok    = CMP_W'(b_addr) < DEPTH_C;
  assign a_wr    = a_gnt & a_we & a_ok;
  assign b_wr    = b_gnt & b_we & b_ok;
  assign a_rd    = a_gnt & ~a_we;
  assign b_rd    = b_gnt & ~b_we;
  assign clr_act = (state == ST_CLEAR);

  // Same-address double write: bytes B also enables are taken from B only.
  assign a_be_eff = (b_wr && (a_addr == b_addr)) ? (a_be & ~b_be) : a_be;

  dmem_dp_array #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .INIT_MODE(INIT_MODE),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .wa_en  (clr_act | a_wr),
    .wa_addr(clr_act ? clr_cnt : a_addr[IDX_W-1:0]),
    .wa_data(clr_act ? '0 : a_wdata),
    .wa_be  (clr_act ? '1 : a_be_eff),
    .wb_en  (b_wr),
    .wb_addr(b_addr[IDX_W-1:0]),
    .wb_data(b_wdata),
    .wb_be  (b_be),
    .ra_en  (a_rd),
    .ra_ok  (a_ok),
    .ra_addr(a_addr[IDX_W-1:0]),
    .ra_data(a_rdata),
    .rb_en  (b_rd),
    .rb_ok  (b_ok),
    .rb_addr(b_addr[IDX_W-1:0]),
    .rb_data(b_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      a_err    <= a_gnt & ~a_ok;
      b_err    <= b_gnt & ~b_ok;
    end
  end

endmodule

// File: tb/tb_dmem_dp.sv
// Randomized scoreboard bench for dmem_dp (INIT_MODE=1, DEPTH=16).
module tb_dmem_dp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;

  typedef struct {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } preq_t;

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [3:0]  a_be, b_be;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, init_done;

  exp_t        q [2][$];
  logic [31:0] last_rd [2];
  logic [31:0] mdl [DEPTH];
  int cyc = 0;
  int rel_edges = 0;
  int n_cmp = 0;
  int n_bad = 0;

  dmem_dp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .INIT_MODE(1), .INIT_FILE("dmem.dat")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_edges <= 0;
    else        rel_edges <= rel_edges + 1;
  end

  // Ready exactly DEPTH+1 clock edges after reset release.
  function automatic bit mdl_ready();
    return rel_edges >= DEPTH + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h required %h", nm, cyc, got, req);
    end
  endtask

  function automatic preq_t mk(input bit req, input bit we, input int addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    preq_t p;
    p.req = req; p.we = we; p.addr = ADDR_W'(addr); p.wdata = wdata; p.be = be;
    return p;
  endfunction

  function automatic preq_t rnd();
    int r;
    int addr;
    r = int'($urandom_range(0, 9));
    if (r < 6)      addr = int'($urandom_range(0, 3));
    else if (r < 9) addr = int'($urandom_range(0, DEPTH - 1));
    else            addr = int'($urandom_range(DEPTH, DEPTH + 5));
    return mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addr,
              $urandom, 4'($urandom_range(0, 15)));
  endfunction

  function automatic void apply_write(input preq_t p);
    for (int i = 0; i < 4; i++)
      if (p.be[i]) mdl[int'(p.addr)][i*8 +: 8] = p.wdata[i*8 +: 8];
  endfunction

  // Expected response for an accepted access; reads see the post-write memory.
  function automatic bit mk_exp(input preq_t p, input int due, output exp_t e);
    bit ok;
    ok = int'(p.addr) < DEPTH;
    e.due = due; e.rd = !p.we; e.err = !ok;
    e.data = (!p.we && ok) ? mdl[int'(p.addr)] : 32'h0;
    return !p.we || !ok;
  endfunction

  task automatic do_cycle(input preq_t pa, input preq_t pb);
    bit ga, gb;
    exp_t e;
    @(negedge clk);
    a_req = pa.req; a_we = pa.we; a_addr = pa.addr; a_wdata = pa.wdata; a_be = pa.be;
    b_req = pb.req; b_we = pb.we; b_addr = pb.addr; b_wdata = pb.wdata; b_be = pb.be;
    #1;
    chk("init_done", 32'(init_done), 32'(mdl_ready()));
    ga = pa.req && mdl_ready();
    gb = pb.req && mdl_ready();
    chk("a_gnt", 32'(a_gnt), 32'(ga));
    chk("b_gnt", 32'(b_gnt), 32'(gb));
    if (ga && pa.we && int'(pa.addr) < DEPTH) apply_write(pa);
    if (gb && pb.we && int'(pb.addr) < DEPTH) apply_write(pb);
    if (ga && mk_exp(pa, cyc + 1, e)) q[0].push_back(e);
    if (gb && mk_exp(pb, cyc + 1, e)) q[1].push_back(e);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_b_rvalid", 32'(b_rvalid), 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_a_err", 32'(a_err), 0);
    chk("rst_b_err", 32'(b_err), 0);
    chk("rst_init_done", 32'(init_done), 0);
  endtask

  task automatic reset_model();
    q[0].delete(); q[1].delete();
    last_rd[0] = 0; last_rd[1] = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
  endtask

  // Assert reset 2ns after a rising edge, check outputs drop, release two negedges later.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    reset_model();
    #1;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++)
      do_cycle(mk(1, 0, i, 0, 0), mk(1, 0, DEPTH - 1 - i, 0, 0));
  endtask

  task automatic mon_port(input int p, input string pn, input logic rv,
                          input logic [31:0] rd, input logic er);
    exp_t e;
    if (rv || er) begin
      if (q[p].size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_unexpected at cycle %0d: got rvalid=%0b err=%0b required no response",
                 pn, cyc, rv, er);
      end else begin
        e = q[p].pop_front();
        chk({pn, "_due"}, 32'(cyc), 32'(e.due));
        chk({pn, "_rvalid"}, 32'(rv), 32'(e.rd));
        chk({pn, "_err"}, 32'(er), 32'(e.err));
        if (e.rd) begin
          chk({pn, "_rdata"}, rd, e.data);
          last_rd[p] = e.data;
        end
      end
    end else if (q[p].size() > 0 && q[p][0].due < cyc) begin
      e = q[p].pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s_missing at cycle %0d: got no response required one due at cycle %0d",
               pn, cyc, e.due);
    end
    if (!rv) chk({pn, "_rdata_hold"}, rd, last_rd[p]);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_port(0, "a", a_rvalid, a_rdata, a_err);
      mon_port(1, "b", b_rvalid, b_rdata, b_err);
    end
  end

  initial begin
    preq_t pa, pb, idle;
    idle = mk(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    reset_model();
    #3;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Clear sweep: nothing granted until cycle DEPTH+1.
    for (int i = 0; i < DEPTH + 1; i++) begin
      pa = rnd(); pa.req = 1'b1;
      pb = rnd(); pb.req = 1'b1;
      do_cycle(pa, pb);
    end
    read_all();

    do_cycle(mk(1, 1, 5, 32'hDEADBEEF, 4'b0011), idle);
    do_cycle(mk(1, 0, 5, 0, 0), idle);
    do_cycle(mk(1, 1, 3, 32'h11111111, 4'b1111), mk(1, 1, 3, 32'h22222222, 4'b1100));
    do_cycle(mk(1, 0, 3, 0, 0), idle);
    do_cycle(mk(1, 1, 7, 32'hCAFEF00D, 4'b1111), mk(1, 0, 7, 0, 0));
    do_cycle(idle, mk(1, 0, DEPTH + 4, 0, 0));
    do_cycle(mk(1, 1, 4, 32'h12345678, 4'b1111), idle);
    do_cycle(mk(1, 1, DEPTH + 4, 32'hFFFFFFFF, 4'b1111), idle);
    do_cycle(mk(1, 0, 4, 0, 0), mk(1, 0, DEPTH + 4, 0, 0));
    do_cycle(mk(1, 1, 4, 32'hA5A5A5A5, 4'b0000), idle);
    do_cycle(idle, mk(1, 0, 4, 0, 0));

    repeat (300) do_cycle(rnd(), rnd());
    read_all();

    // Reset while a read response is in flight.
    do_cycle(mk(1, 0, 5, 0, 0), mk(1, 0, 7, 0, 0));
    pulse_reset();

    // Reset again with the clear counter at 9.
    repeat (9) do_cycle(rnd(), rnd());
    pulse_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      pa = rnd(); pa.req = 1'b1;
      do_cycle(pa, rnd());
    end
    read_all();
    repeat (200) do_cycle(rnd(), rnd());
    read_all();
    do_cycle(idle, idle);
    repeat (3) @(negedge clk);
    #1;
    chk("a_drain", 32'(q[0].size()), 0);
    chk("b_drain", 32'(q[1].size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before 500000ns");
    $fatal(1);
  end

endmodule
